// File: rtl/fetch_entry_buffer.sv
// Circular fetch-entry FIFO between the I-cache fetch port and the instruction realigner.
// Optional same-cycle empty-buffer bypass is enabled by defining FETCH_BUFFER_BYPASS_EN.
module fetch_entry_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [63:0]                in_address_i,
   input  logic [31:0]                in_instr_i,
   input  logic                       in_bp_valid_i,
   input  logic                       in_bp_predict_taken_i,
   input  logic [1:0]                 in_bp_taken_i,
   input  logic                       in_page_fault_i,
   output logic                       out_valid_o,
   input  logic                       out_ack_i,
   output logic [63:0]                out_address_o,
   output logic [31:0]                out_instr_o,
   output logic                       out_bp_valid_o,
   output logic                       out_bp_predict_taken_o,
   output logic [1:0]                 out_bp_taken_o,
   output logic                       out_page_fault_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [63:0] address;
      logic [31:0] instr;
      logic        bp_valid;
      logic        bp_predict_taken;
      logic [1:0]  bp_taken;
      logic        page_fault;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]   count_q;

   entry_t in_entry, head;
   logic   empty, full, push, pop;

   assign in_entry = '{address:          in_address_i,
                       instr:            in_instr_i,
                       bp_valid:         in_bp_valid_i,
                       bp_predict_taken: in_bp_predict_taken_i,
                       bp_taken:         in_bp_taken_i,
                       page_fault:       in_page_fault_i};

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign in_ready_o = !flush_i && !full;

`ifdef FETCH_BUFFER_BYPASS_EN
   logic bypass;

   // An empty buffer forwards the incoming beat; an acked bypassed beat is never stored.
   assign bypass      = empty && in_valid_i && !flush_i;
   assign out_valid_o = (!empty && !flush_i) || bypass;
   assign head        = bypass ? in_entry : mem_q[rd_ptr_q];
   assign pop         = out_ack_i && out_valid_o && !empty;
   assign push        = in_valid_i && in_ready_o && !(bypass && out_ack_i);
`else
   assign out_valid_o = !empty && !flush_i;
   assign head        = mem_q[rd_ptr_q];
   assign pop         = out_ack_i && out_valid_o;
   assign push        = in_valid_i && in_ready_o;
`endif

   assign out_address_o          = head.address;
   assign out_instr_o            = head.instr;
   assign out_bp_valid_o         = head.bp_valid;
   assign out_bp_predict_taken_o = head.bp_predict_taken;
   assign out_bp_taken_o         = head.bp_taken;
   assign out_page_fault_o       = head.page_fault;
   assign count_o                = count_q;

   // Pointer, occupancy and storage update; flush resets pointers but keeps storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
